mem_arbiter: RTL and testbench

Parametrised N-master memory arbiter replacing the fixed two-port IFU/LSU memory hookup. It accepts valid/response-handshaked requests from NUM_MASTERS requesters (IFU, LSU, and future DMA/debug ports), serialises them onto one SRAM-style memory port with a fixed configurable read latency, and returns a one-cycle response to the winner. Fixed-priority and round-robin arbitration are selectable, and back-to-back grants to different masters are supported.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signal bundle for mem_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int MW = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_reqValid;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS-1:0]            m_wen;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS*MW-1:0]         m_wmask;
    logic [NUM_MASTERS-1:0]            m_respValid;
    logic [DATA_WIDTH-1:0]             m_rdata;

    logic                  mem_en;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MW-1:0]         mem_wmask;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  m_reqValid, m_addr, m_wen, m_wdata, m_wmask, mem_rdata,
        output m_respValid, m_rdata, mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output m_reqValid, m_addr, m_wen, m_wdata, m_wmask, mem_rdata,
        input  m_respValid, m_rdata, mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-master arbiter serialising requests onto one fixed-latency SRAM port.
// Fixed-priority or round-robin selection; the just-served master is skipped in RESP.
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int RR_MODE     = 1,
    localparam int GW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
    localparam int MW = DATA_WIDTH / 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic [GW-1:0] grant_idx
);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_q, wr_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
    logic [MW-1:0]         wmask_arr [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_arr[g]  = bus.m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = bus.m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign wmask_arr[g] = bus.m_wmask[g*MW +: MW];
    end

    // Winner search; in RESP the master being answered is masked so others get a turn.
    logic [NUM_MASTERS-1:0] arb_req;
    logic [GW-1:0]          arb_start, arb_win, arb_sel;
    logic                   arb_found;

    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        idx       = 0;
        arb_sel   = '0;
        arb_win   = '0;
        arb_found = 1'b0;
        arb_req   = bus.m_reqValid;
        if (state_q == RESP) arb_req[grant_q] = 1'b0;
        arb_start = (RR_MODE != 0) ? rr_ptr_q : '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(arb_start) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            arb_sel = GW'(idx);
            if (!arb_found && arb_req[arb_sel]) begin
                arb_found = 1'b1;
                arb_win   = arb_sel;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        wr_d     = wr_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (arb_found) begin
                    state_d  = ISSUE;
                    grant_d  = arb_win;
                    rr_ptr_d = (int'(arb_win) == NUM_MASTERS - 1) ? '0 : arb_win + GW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(MEM_LATENCY - 1);
                wr_d    = bus.m_wen[grant_q];
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = wr_q ? '0 : bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes and data are only non-zero while ISSUE is the registered state.
    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_wmask   = '0;
        bus.m_respValid = '0;
        if (state_q == ISSUE) begin
            bus.mem_en    = 1'b1;
            bus.mem_wen   = bus.m_wen[grant_q];
            bus.mem_addr  = addr_arr[grant_q];
            bus.mem_wdata = wdata_arr[grant_q];
            bus.mem_wmask = wmask_arr[grant_q];
        end
        if (state_q == RESP) bus.m_respValid[grant_q] = 1'b1;
    end

    assign bus.m_rdata = rdata_q;
    assign busy        = (state_q != IDLE);
    assign grant_idx   = grant_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut_a = 2 masters, latency 1, fixed priority;
// dut_b = 4 masters, latency 4, round-robin.
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       busy_a, busy_b;
    logic [0:0] grant_a;
    logic [1:0] grant_b;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.NUM_MASTERS(2)) bus_a ();
    mem_arbiter_if #(.NUM_MASTERS(4)) bus_b ();

    mem_arbiter #(.NUM_MASTERS(2), .MEM_LATENCY(1), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .busy(busy_a), .grant_idx(grant_a)
    );
    mem_arbiter #(.NUM_MASTERS(4), .MEM_LATENCY(4), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .busy(busy_b), .grant_idx(grant_b)
    );

    // dut_b memory returns a value tagged with the current cycle number
    assign bus_b.mem_rdata = {16'hCAFE, cyc[15:0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit use_b, input bit want_resp, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (want_resp) hit = use_b ? (|bus_b.m_respValid) : (|bus_a.m_respValid);
            else           hit = use_b ? bus_b.mem_en : bus_a.mem_en;
            if (!hit) tick();
        end
        check({tag, "_seen"}, 64'(hit), 64'd1);
    endtask

    logic [1:0] fp_oh [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0] rr_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_gi [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        int nw, t0, t1, last_en;
        logic [31:0] tag;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.m_reqValid = '0; bus_a.m_addr = '0; bus_a.m_wen = '0;
        bus_a.m_wdata = '0; bus_a.m_wmask = '0; bus_a.mem_rdata = '0;
        bus_b.m_reqValid = '0; bus_b.m_addr = '0; bus_b.m_wen = '0;
        bus_b.m_wdata = '0; bus_b.m_wmask = '0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("rst_busy_a", 64'(busy_a), 0);
        check("rst_grant_a", 64'(grant_a), 0);
        check("rst_en_a", 64'(bus_a.mem_en), 0);
        check("rst_resp_a", 64'(bus_a.m_respValid), 0);
        check("rst_rdata_a", 64'(bus_a.m_rdata), 0);
        check("rst_addr_a", 64'(bus_a.mem_addr), 0);
        check("rst_busy_b", 64'(busy_b), 0);
        check("rst_resp_b", 64'(bus_b.m_respValid), 0);

        // single read, master 1, latency 1
        bus_a.mem_rdata = 32'hDEAD_BEEF;
        bus_a.m_addr[63:32] = 32'h8000_0004;
        bus_a.m_reqValid = 2'b10;
        check("rd_c0_en", 64'(bus_a.mem_en), 0);
        tick();
        check("rd_c1_en", 64'(bus_a.mem_en), 1);
        check("rd_c1_addr", 64'(bus_a.mem_addr), 64'h8000_0004);
        check("rd_c1_wen", 64'(bus_a.mem_wen), 0);
        check("rd_c1_grant", 64'(grant_a), 1);
        tick();
        check("rd_c2_en", 64'(bus_a.mem_en), 0);
        check("rd_c2_resp", 64'(bus_a.m_respValid), 0);
        tick();
        check("rd_c3_resp", 64'(bus_a.m_respValid), 64'b10);
        check("rd_c3_rdata", 64'(bus_a.m_rdata), 64'hDEAD_BEEF);
        bus_a.m_reqValid = '0;
        tick();
        check("rd_c4_resp", 64'(bus_a.m_respValid), 0);
        check("rd_c4_busy", 64'(busy_a), 0);

        // write, master 0; response data must be zero even with memory driving ones
        bus_a.mem_rdata = 32'hFFFF_FFFF;
        bus_a.m_addr[31:0] = 32'h8000_0010;
        bus_a.m_wdata[31:0] = 32'h1234_5678;
        bus_a.m_wmask[3:0] = 4'b0011;
        bus_a.m_wen = 2'b01;
        bus_a.m_reqValid = 2'b01;
        nw = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (bus_a.mem_wen) nw++;
            if (c == 1) begin
                check("wr_addr", 64'(bus_a.mem_addr), 64'h8000_0010);
                check("wr_wdata", 64'(bus_a.mem_wdata), 64'h1234_5678);
                check("wr_wmask", 64'(bus_a.mem_wmask), 64'b0011);
            end
            if (c == 3) begin
                check("wr_resp", 64'(bus_a.m_respValid), 64'b01);
                check("wr_rdata", 64'(bus_a.m_rdata), 0);
                bus_a.m_reqValid = '0;
                bus_a.m_wen = '0;
            end
        end
        check("wr_wen_cycles", 64'(nw), 1);
        check("wr_wdata_idle", 64'(bus_a.mem_wdata), 0);

        // fixed priority with both masters always requesting
        bus_a.mem_rdata = 32'h55;
        bus_a.m_addr = {32'h200, 32'h100};
        bus_a.m_reqValid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_for(1'b0, 1'b1, "fp_resp");
            check("fp_onehot", 64'(bus_a.m_respValid), 64'(fp_oh[k]));
            check("fp_rdata", 64'(bus_a.m_rdata), 64'h55);
            tick();
            check("fp_pulse_len", 64'(bus_a.m_respValid), 0);
        end
        bus_a.m_reqValid = '0;
        for (int i = 0; i < 6; i++) tick();

        // same master back-to-back goes through IDLE: period latency+3
        bus_a.m_reqValid = 2'b01;
        wait_for(1'b0, 1'b0, "same_en0");
        t0 = cyc;
        tick();
        wait_for(1'b0, 1'b0, "same_en1");
        t1 = cyc;
        check("same_period", 64'(t1 - t0), 4);
        bus_a.m_reqValid = '0;
        for (int i = 0; i < 6; i++) tick();
        check("same_idle", 64'(busy_a), 0);

        // reset during WAIT abandons the access
        bus_a.mem_rdata = 32'h1111;
        bus_a.m_reqValid = 2'b10;
        tick();
        check("rw_c1_en", 64'(bus_a.mem_en), 1);
        tick();
        check("rw_c2_busy", 64'(busy_a), 1);
        rst_a = 1'b1;
        bus_a.m_reqValid = '0;
        tick();
        rst_a = 1'b0;
        check("rw_busy", 64'(busy_a), 0);
        check("rw_resp", 64'(bus_a.m_respValid), 0);
        check("rw_grant", 64'(grant_a), 0);
        check("rw_rdata", 64'(bus_a.m_rdata), 0);
        tick();
        check("rw_resp_after", 64'(bus_a.m_respValid), 0);
        bus_a.mem_rdata = 32'hA5A5_0001;
        bus_a.m_addr[31:0] = 32'h300;
        bus_a.m_reqValid = 2'b01;
        tick();
        check("rw_new_en", 64'(bus_a.mem_en), 1);
        check("rw_new_addr", 64'(bus_a.mem_addr), 64'h300);
        tick();
        tick();
        check("rw_new_resp", 64'(bus_a.m_respValid), 64'b01);
        check("rw_new_rdata", 64'(bus_a.m_rdata), 64'hA5A5_0001);
        bus_a.m_reqValid = '0;

        // round-robin, four masters always requesting
        for (int i = 0; i < 4; i++) bus_b.m_addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
        bus_b.m_reqValid = 4'hF;
        last_en = 0;
        for (int k = 0; k < 5; k++) begin
            wait_for(1'b1, 1'b0, "rr_en");
            check("rr_grant", 64'(grant_b), 64'(rr_gi[k]));
            check("rr_addr", 64'(bus_b.mem_addr), 64'h1000 + 64'(rr_gi[k]) * 16);
            if (k > 0) check("rr_period", 64'(cyc - last_en), 6);
            last_en = cyc;
            wait_for(1'b1, 1'b1, "rr_resp");
            check("rr_onehot", 64'(bus_b.m_respValid), 64'(rr_oh[k]));
            tick();
            check("rr_pulse_len", 64'(bus_b.m_respValid), 0);
        end
        bus_b.m_reqValid = '0;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;

        // latency 4: response at cycle 6 carries the data present at cycle 5
        bus_b.m_addr[95:64] = 32'h2000_0000;
        bus_b.m_reqValid = 4'b0100;
        tick();
        check("lat_c1_en", 64'(bus_b.mem_en), 1);
        check("lat_c1_grant", 64'(grant_b), 2);
        tick();
        check("lat_c2_en", 64'(bus_b.mem_en), 0);
        tick();
        tick();
        tick();
        tag = {16'hCAFE, cyc[15:0]};
        check("lat_c5_resp", 64'(bus_b.m_respValid), 0);
        tick();
        check("lat_c6_resp", 64'(bus_b.m_respValid), 64'b0100);
        check("lat_c6_rdata", 64'(bus_b.m_rdata), 64'(tag));
        bus_b.m_reqValid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
